// File: rtl/width_packer_buffer.sv
// Packs a byte stream little-endian into words, buffers them in side-by-side EBR slices
// and presents them on a ready/valid port. Define WIDTH_PACKER_BUFFER_FLUSH_EN to add the flush input.
module width_packer_buffer #(
  parameter int input_width  = 8,
  parameter int output_width = 32,
  parameter int buffer_width = 16,
  parameter int buffer_depth = 256,
  parameter int num_ebrs     = ((output_width - 1) / buffer_width) + 1,
  parameter int ratio        = output_width / input_width
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          data_in_valid,
  input  logic [input_width-1:0]        data_in,
`ifdef WIDTH_PACKER_BUFFER_FLUSH_EN
  input  logic                          flush,
`endif
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic [output_width-1:0]       data_out,
  output logic [$clog2(buffer_depth):0] fill_level,
  output logic                          overflow
);

  localparam int ADDR_W  = $clog2(buffer_depth);
  localparam int FILL_W  = ADDR_W + 1;
  localparam int SLICE_W = (ratio > 1) ? $clog2(ratio) : 1;
  localparam int PAD_W   = num_ebrs * buffer_width;

  typedef enum logic [1:0] {EMPTY, FETCH, VALID} state_t;

  genvar gi;

  logic                    flush_req;
  logic                    in_valid_reg;
  logic [input_width-1:0]  in_data_reg;
  logic                    in_flush_reg;

  logic [SLICE_W-1:0]      slice_reg, slice_next, slice_after;
  logic [output_width-1:0] accumulator_reg, accumulator_next, acc_byte;
  logic                    byte_done, word_done, wr_en, pop;

  logic [ADDR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [FILL_W-1:0]       fill_level_reg;
  logic                    overflow_reg;

  logic [PAD_W-1:0]        wdata_pad, rdata_pad;
  logic [output_width-1:0] ebr_dout;

  state_t                  state_reg;
  logic [output_width-1:0] data_out_reg;
  logic                    data_out_valid_reg;

`ifdef WIDTH_PACKER_BUFFER_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Input capture stage; packing works on the registered byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_valid_reg <= 1'b0;
      in_data_reg  <= '0;
      in_flush_reg <= 1'b0;
    end else begin
      in_valid_reg <= data_in_valid;
      in_data_reg  <= data_in;
      in_flush_reg <= flush_req;
    end
  end

  for (gi = 0; gi < ratio; gi++) begin : g_lane
    assign acc_byte[gi*input_width +: input_width] =
      (in_valid_reg && (slice_reg == SLICE_W'(gi))) ? in_data_reg
                                                     : accumulator_reg[gi*input_width +: input_width];
  end

  assign byte_done = in_valid_reg && (slice_reg == SLICE_W'(ratio - 1));

  // The accumulator is zeroed after every word, so a flushed partial word has zero upper bytes.
  always_comb begin
    slice_after = slice_reg;
    if (in_valid_reg) begin
      slice_after = byte_done ? '0 : slice_reg + SLICE_W'(1);
    end
    word_done        = byte_done || (in_flush_reg && (slice_after != '0));
    slice_next       = word_done ? '0 : slice_after;
    accumulator_next = word_done ? '0 : acc_byte;
  end

  assign wr_en = word_done && (fill_level_reg < FILL_W'(buffer_depth));
  assign pop   = (state_reg == FETCH);

  always_ff @(posedge clock) begin
    if (reset) begin
      slice_reg       <= '0;
      accumulator_reg <= '0;
      wr_ptr_reg      <= '0;
      fill_level_reg  <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      slice_reg       <= slice_next;
      accumulator_reg <= accumulator_next;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end
      fill_level_reg  <= fill_level_reg + FILL_W'(wr_en) - FILL_W'(pop);
      if (word_done && !wr_en) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign wdata_pad = PAD_W'(acc_byte);

  // One block RAM slice per EBR, read address tracks rd_ptr continuously.
  for (gi = 0; gi < num_ebrs; gi++) begin : g_ebr
    logic [buffer_width-1:0] mem [buffer_depth];
    logic [buffer_width-1:0] dout_reg;

    always_ff @(posedge clock) begin
      if (wr_en) begin
        mem[wr_ptr_reg] <= wdata_pad[gi*buffer_width +: buffer_width];
      end
      dout_reg <= mem[rd_ptr_reg];
    end

    assign rdata_pad[gi*buffer_width +: buffer_width] = dout_reg;
  end

  assign ebr_dout = rdata_pad[output_width-1:0];

  // A word written this cycle is not yet visible on the EBR read port, so the
  // handshake only chains straight into FETCH for words already stored.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg          <= EMPTY;
      rd_ptr_reg         <= '0;
      data_out_reg       <= '0;
      data_out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        EMPTY: begin
          data_out_valid_reg <= 1'b0;
          if (fill_level_reg != '0) begin
            state_reg <= FETCH;
          end
        end
        FETCH: begin
          data_out_reg       <= ebr_dout;
          data_out_valid_reg <= 1'b1;
          rd_ptr_reg         <= rd_ptr_reg + ADDR_W'(1);
          state_reg          <= VALID;
        end
        VALID: begin
          if (data_out_ready) begin
            data_out_valid_reg <= 1'b0;
            state_reg          <= (fill_level_reg != '0) ? FETCH : EMPTY;
          end
        end
        default: begin
          state_reg          <= EMPTY;
          data_out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign data_out       = data_out_reg;
  assign data_out_valid = data_out_valid_reg;
  assign fill_level     = fill_level_reg;
  assign overflow       = overflow_reg;

endmodule

// File: tb/tb_width_packer_buffer.sv
// Randomised bench for width_packer_buffer: a queue-based packing model and one
// compare process that checks every handshake and output stability each cycle.
module tb_width_packer_buffer;

  localparam int IW    = 8;
  localparam int OW    = 32;
  localparam int DEPTH = 256;
  localparam int RATIO = OW / IW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          data_in_valid = 1'b0;
  logic [IW-1:0] data_in = '0;
  logic          data_out_valid;
  logic          data_out_ready = 1'b0;
  logic [OW-1:0] data_out;
  logic [8:0]    fill_level;
  logic          overflow;
`ifdef WIDTH_PACKER_BUFFER_FLUSH_EN
  logic          flush = 1'b0;
`endif

  always #5 clock = ~clock;

  width_packer_buffer dut (
    .clock          (clock),
    .reset          (reset),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
`ifdef WIDTH_PACKER_BUFFER_FLUSH_EN
    .flush          (flush),
`endif
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out       (data_out),
    .fill_level     (fill_level),
    .overflow       (overflow)
  );

  int          checks_total  = 0;
  int          checks_passed = 0;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] model_word = '0;
  int            model_k = 0;
  bit            model_overflow = 1'b0;

  int            ready_mode = 0;
  bit            ready_manual = 1'b0;
  bit            stall_prev = 1'b0;
  logic [OW-1:0] stall_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks_total++;
    if (act === req) checks_passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic void model_clear();
    exp_q.delete();
    model_word     = '0;
    model_k        = 0;
    model_overflow = 1'b0;
  endfunction

  // With the consumer stalled, storage is the FIFO plus the output register.
  function automatic void model_enqueue(input logic [OW-1:0] w);
    if (exp_q.size() < DEPTH + 1) exp_q.push_back(w);
    else model_overflow = 1'b1;
  endfunction

  function automatic void model_byte(input logic [IW-1:0] b);
    model_word[model_k*IW +: IW] = b;
    model_k++;
    if (model_k == RATIO) begin
      model_enqueue(model_word);
      model_word = '0;
      model_k    = 0;
    end
  endfunction

  function automatic void model_flush();
    if (model_k != 0) begin
      model_enqueue(model_word);
      model_word = '0;
      model_k    = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [IW-1:0] b);
    data_in       = b;
    data_in_valid = 1'b1;
    model_byte(b);
    tick();
    data_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || data_out_valid) && i < budget) begin
      tick();
      i++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_valid_low", data_out_valid, 1'b0);
    check("drain_fill_zero", fill_level, 0);
  endtask

  // Ready driver: manual level, toggle each cycle, or random.
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      1:       data_out_ready = ~data_out_ready;
      2:       data_out_ready = ($urandom_range(0, 99) < 60);
      default: data_out_ready = ready_manual;
    endcase
  end

  // Compare process: every handshake against the model, and stability while stalled.
  always @(negedge clock) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", data_out_valid, 1'b1);
        check("stall_data_held", data_out, stall_data);
      end
      if (data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) begin
          checks_total++;
          $display("FAIL unexpected_word: got %0h, required no word", data_out);
        end else begin
          check("word", data_out, exp_q.pop_front());
        end
      end
      stall_prev = data_out_valid && !data_out_ready;
      stall_data = data_out;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("reset_valid", data_out_valid, 1'b0);
    check("reset_data", data_out, 0);
    check("reset_fill", fill_level, 0);
    check("reset_overflow", overflow, 1'b0);
    reset = 1'b0;
    model_clear();

    // Single word, latency and one-cycle valid
    ready_manual = 1'b1;
    tick();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    check("model_word0", exp_q[0], 32'h44332211);
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (n < 3) check("latency_early_low", data_out_valid, 1'b0);
      if (n == 3) begin
        check("latency_valid_3", data_out_valid, 1'b1);
        check("latency_data", data_out, 32'h44332211);
      end
      if (n == 4) check("valid_one_cycle", data_out_valid, 1'b0);
    end
    check("single_fill_zero", fill_level, 0);

    // Two words with consumer stalled
    ready_manual = 1'b0;
    tick();
    for (int b = 1; b <= 8; b++) send_byte(IW'(b));
    repeat (8) tick();
    check("stall_head_data", data_out, 32'h04030201);
    check("stall_head_valid", data_out_valid, 1'b1);
    check("stall_fill_one", fill_level, 1);
    check("model_words_two", exp_q.size(), 2);
    check("model_word1", exp_q[1], 32'h08070605);
    ready_manual = 1'b1;
    drain(50);

    // Reset mid-word while a word is presented
    ready_manual = 1'b0;
    tick();
    for (int b = 0; b < 4; b++) send_byte(8'h50 + IW'(b));
    repeat (5) tick();
    send_byte(8'h61);
    send_byte(8'h62);
    reset = 1'b1;
    model_clear();
    tick();
    check("midreset_valid", data_out_valid, 1'b0);
    check("midreset_data", data_out, 0);
    check("midreset_fill", fill_level, 0);
    check("midreset_overflow", overflow, 1'b0);
    reset = 1'b0;
    for (int b = 0; b < 4; b++) send_byte(8'hA0 + IW'(b));
    check("model_after_reset", exp_q[0], 32'hA3A2A1A0);
    ready_manual = 1'b1;
    drain(50);

    // Fill to capacity, then overflow
    ready_manual = 1'b0;
    tick();
    for (int w = 0; w < DEPTH + 1; w++)
      for (int b = 0; b < RATIO; b++) send_byte(IW'($urandom));
    repeat (6) tick();
    check("full_fill", fill_level, DEPTH);
    check("full_no_overflow", overflow, 1'b0);
    check("model_full_size", exp_q.size(), DEPTH + 1);
    for (int b = 0; b < RATIO; b++) send_byte(IW'($urandom));
    repeat (6) tick();
    check("overflow_set", overflow, 1'b1);
    check("overflow_fill", fill_level, DEPTH);
    check("model_overflow", model_overflow, 1'b1);
    ready_manual = 1'b1;
    drain(3000);
    check("overflow_sticky", overflow, 1'b1);
    do_reset();
    check("overflow_cleared", overflow, 1'b0);

    // Pointer wrap with toggling ready
    ready_mode = 1;
    for (int w = 0; w < 3 * DEPTH; w++)
      for (int b = 0; b < RATIO; b++) send_byte(IW'($urandom));
    drain(2000);
    check("wrap_overflow", overflow, 1'b0);
    check("wrap_model_overflow", model_overflow, 1'b0);

    // Random gaps on both sides
    ready_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 70) send_byte(IW'($urandom));
      else tick();
    end
    while (model_k != 0) send_byte(IW'($urandom));
    drain(2000);
    check("random_overflow", overflow, 1'b0);

`ifdef WIDTH_PACKER_BUFFER_FLUSH_EN
    ready_mode   = 0;
    ready_manual = 1'b1;
    do_reset();
    send_byte(8'hAA);
    send_byte(8'hBB);
    flush = 1'b1;
    model_flush();
    tick();
    flush = 1'b0;
    check("model_flush_word", exp_q[0], 32'h0000BBAA);
    drain(50);
    flush = 1'b1;
    model_flush();
    tick();
    flush = 1'b0;
    repeat (6) tick();
    check("idle_flush_valid", data_out_valid, 1'b0);
    check("idle_flush_fill", fill_level, 0);
    check("idle_flush_model", exp_q.size(), 0);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
